// File: rtl/spi_packet_master.sv
// spi_packet_master: CPOL=0/CPHA=0 SPI master that sends one sample packet and captures the result packet from MISO.
module spi_packet_master #(
  parameter int SAMPLES_NUM = 8,
  parameter int CLK_DIV = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_GAP = 4
) (
  input  logic                      clk,
  input  logic                      nResetIn,
  input  logic                      startIn,
  input  logic                      abortIn,
  input  logic [16*SAMPLES_NUM-1:0] samplesIn,
  output logic [32*SAMPLES_NUM-1:0] resultsOut,
  output logic                      doneOut,
  output logic                      busyOut,
  output logic                      ssOut,
  output logic                      sckOut,
  output logic                      mosiOut,
  input  logic                      misoIn
);
  localparam int TOTAL_BITS = SAMPLES_NUM * 32;
  localparam int BW = $clog2(TOTAL_BITS);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, LOW = 3'd2, HIGH = 3'd3, HOLD = 3'd4, GAP = 3'd5;
  logic [2:0] state;
  logic [15:0] cnt, limit;
  logic [BW-1:0] bitCount;
  logic [TOTAL_BITS-2:0] txReg;
  logic [TOTAL_BITS-1:0] rxReg;
  logic tick, active;
  always_comb begin
    limit = state == SETUP ? 16'(SS_SETUP - 1) : state == GAP ? 16'(SS_GAP - 1) : 16'(CLK_DIV - 1);
    tick = cnt == limit;
    active = state == SETUP || state == LOW || state == HIGH || state == HOLD;
  end
  // txReg holds only the bits still to be sent; the current bit already sits in mosiOut
  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      state <= IDLE;
      cnt <= '0;
      bitCount <= '0;
      txReg <= '0;
      rxReg <= '0;
      resultsOut <= '0;
      doneOut <= 1'b0;
      busyOut <= 1'b0;
      ssOut <= 1'b1;
      sckOut <= 1'b0;
      mosiOut <= 1'b0;
    end else begin
      doneOut <= 1'b0;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 16'd1;
      if (abortIn && active) begin
        ssOut <= 1'b1;
        sckOut <= 1'b0;
        mosiOut <= 1'b0;
        cnt <= '0;
        state <= GAP;
      end else begin
        case (state)
          IDLE: if (startIn && !abortIn) begin
            txReg <= {samplesIn[16*SAMPLES_NUM-2:0], {16*SAMPLES_NUM{1'b0}}};
            mosiOut <= samplesIn[16*SAMPLES_NUM-1];
            ssOut <= 1'b0;
            busyOut <= 1'b1;
            bitCount <= '0;
            state <= SETUP;
          end
          SETUP: if (tick) state <= LOW;
          LOW: if (tick) begin
            sckOut <= 1'b1;
            state <= HIGH;
          end
          HIGH: if (tick) begin
            sckOut <= 1'b0;
            rxReg <= {rxReg[TOTAL_BITS-2:0], misoIn};
            if (bitCount < BW'(TOTAL_BITS - 1)) begin
              bitCount <= bitCount + BW'(1);
              txReg <= {txReg[TOTAL_BITS-3:0], 1'b0};
              mosiOut <= txReg[TOTAL_BITS-2];
              state <= LOW;
            end else begin
              mosiOut <= 1'b0;
              state <= HOLD;
            end
          end
          HOLD: if (tick) begin
            ssOut <= 1'b1;
            resultsOut <= rxReg;
            doneOut <= 1'b1;
            state <= GAP;
          end
          GAP: if (tick) begin
            busyOut <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_packet_master.sv
// tb_spi_packet_master: directed sequence with random data, checked against a packet-level SPI model.
module tb_spi_packet_master;
  localparam int N = 2, DIV = 3, SETUP = 2, GAP = 4;
  localparam int TOT = N * 32;
  localparam int LAT = 1 + SETUP + 2 * DIV * TOT + DIV;
  logic clk = 0, nResetIn = 0, startIn = 0, abortIn = 0, misoIn, loopMode = 0;
  logic [16*N-1:0] samplesIn = '0;
  logic [32*N-1:0] resultsOut, slaveWord = '0, lastRes = '0;
  logic doneOut, busyOut, ssOut, sckOut, mosiOut;
  int checks = 0, failures = 0;
  int cyc = 0, rises = 0, doneCount = 0, ssFalls = 0, ssRun = 1000, lastGap = 0, sckSsHigh = 0;
  int sIdx = TOT - 1;
  int t0, rise0, q0, done0, falls0, doneCyc;
  logic prevSck = 0, prevSs = 1;
  logic mosiQ[$];
  logic [16*N-1:0] curSamples;
  logic [32*N-1:0] curExp;

  spi_packet_master #(.SAMPLES_NUM(N), .CLK_DIV(DIV), .SS_SETUP(SETUP), .SS_GAP(GAP)) dut (
    .clk(clk), .nResetIn(nResetIn), .startIn(startIn), .abortIn(abortIn), .samplesIn(samplesIn),
    .resultsOut(resultsOut), .doneOut(doneOut), .busyOut(busyOut), .ssOut(ssOut), .sckOut(sckOut),
    .mosiOut(mosiOut), .misoIn(misoIn));

  always #5 clk = ~clk;

  // Slave: presents its MSB when selected, advances on each SCK falling edge
  always @(negedge ssOut) sIdx = TOT - 1;
  always @(negedge sckOut) if (!ssOut && sIdx > 0) sIdx = sIdx - 1;
  assign misoIn = loopMode ? mosiOut : slaveWord[sIdx];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (sckOut && !prevSck) begin
      rises++;
      mosiQ.push_back(mosiOut);
    end
    if (sckOut && ssOut) sckSsHigh++;
    if (doneOut) doneCount++;
    if (!ssOut && prevSs) begin
      ssFalls++;
      lastGap = ssRun;
    end
    ssRun = ssOut ? ssRun + 1 : 0;
    prevSck = sckOut;
    prevSs = ssOut;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge
  task automatic start_pkt(input logic lp);
    curSamples = {$urandom, $urandom};
    slaveWord = {$urandom, $urandom};
    loopMode = lp;
    curExp = lp ? {curSamples, 32'h0} : slaveWord;
    samplesIn = curSamples;
    startIn = 1;
    t0 = cyc;
    rise0 = rises;
    q0 = mosiQ.size();
    done0 = doneCount;
    @(negedge clk);
    startIn = 0;
    samplesIn = {$urandom, $urandom};
  endtask

  task automatic finish_pkt(input string tag);
    logic [63:0] mw;
    for (int i = 0; i < LAT + 100 && !doneOut; i++) @(negedge clk);
    check({tag, "_done"}, doneOut, 1'b1);
    check({tag, "_latency"}, cyc - t0, LAT);
    check({tag, "_ss_at_done"}, ssOut, 1'b1);
    check({tag, "_results"}, resultsOut, curExp);
    check({tag, "_sck_rises"}, rises - rise0, TOT);
    mw = '0;
    for (int i = 0; i < TOT; i++) mw = {mw[62:0], (q0 + i < mosiQ.size()) ? mosiQ[q0 + i] : 1'bx};
    check({tag, "_mosi_stream"}, mw, {curSamples, 32'h0});
    lastRes = curExp;
    doneCyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < GAP + 20 && busyOut; i++) @(negedge clk);
    check({tag, "_busy_fall"}, cyc - doneCyc, GAP);
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < LAT && rises - rise0 < n; i++) @(negedge clk);
    check("wait_rises", rises - rise0, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ss", ssOut, 1'b1);
    check("rst_sck", sckOut, 1'b0);
    check("rst_mosi", mosiOut, 1'b0);
    check("rst_busy", busyOut, 1'b0);
    check("rst_done", doneOut, 1'b0);
    check("rst_results", resultsOut, 64'h0);
    nResetIn = 1;
    @(negedge clk);
    start_pkt(1'b1);
    finish_pkt("loop");
    wait_idle("loop");
    start_pkt(1'b0);
    finish_pkt("slave");
    wait_idle("slave");
    @(negedge clk);
    falls0 = ssFalls;
    start_pkt(1'b0);
    for (int i = 0; i < 200 && !(sckOut && rises - rise0 >= 3); i++) @(negedge clk);
    startIn = 1;
    @(negedge clk);
    startIn = 0;
    finish_pkt("ign");
    startIn = 1;
    @(negedge clk);
    startIn = 0;
    wait_idle("ign");
    repeat (6) @(negedge clk);
    check("ign_single_done", doneCount - done0, 1);
    check("ign_single_ss", ssFalls - falls0, 1);
    check("ign_busy", busyOut, 1'b0);
    startIn = 1;
    abortIn = 1;
    @(negedge clk);
    startIn = 0;
    abortIn = 0;
    check("abort_start_busy", busyOut, 1'b0);
    check("abort_start_ss", ssOut, 1'b1);
    start_pkt(1'b0);
    wait_rises(10);
    abortIn = 1;
    doneCyc = cyc + 1;
    @(negedge clk);
    abortIn = 0;
    check("abort_ss", ssOut, 1'b1);
    check("abort_sck", sckOut, 1'b0);
    check("abort_mosi", mosiOut, 1'b0);
    wait_idle("abort");
    check("abort_no_done", doneCount - done0, 0);
    check("abort_results", resultsOut, lastRes);
    start_pkt(1'b0);
    finish_pkt("post_abort");
    wait_idle("post_abort");
    start_pkt(1'b1);
    wait_rises(20);
    nResetIn = 0;
    #1;
    check("mid_rst_ss", ssOut, 1'b1);
    check("mid_rst_sck", sckOut, 1'b0);
    check("mid_rst_mosi", mosiOut, 1'b0);
    check("mid_rst_busy", busyOut, 1'b0);
    check("mid_rst_results", resultsOut, 64'h0);
    @(negedge clk);
    nResetIn = 1;
    @(negedge clk);
    start_pkt(1'b0);
    finish_pkt("post_rst");
    wait_idle("post_rst");
    done0 = doneCount;
    start_pkt(1'b0);
    finish_pkt("b2b_a");
    wait_idle("b2b_a");
    start_pkt(1'b1);
    finish_pkt("b2b_b");
    check("b2b_gap_ok", lastGap >= GAP, 1'b1);
    wait_idle("b2b_b");
    check("b2b_sck_while_ss_high", sckSsHigh, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
